// File: rtl/id_issue_stage_if.sv
// Bundle of every signal between the decode/issue stage and its neighbours:
// fetch, the register file, writeback, the branch-flush source and the EX stage.
// The slave modport is the stage's own view; the master modport is the view
// of whatever surrounds it.
interface id_issue_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic [4:0]      rf_rd_addr1;
    logic [4:0]      rf_rd_addr2;
    logic [XLEN-1:0] rf_rd_data1;
    logic [XLEN-1:0] rf_rd_data2;

    logic            wb_valid;
    logic [4:0]      wb_reg;
    logic [XLEN-1:0] wb_data;

    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic            out_regwrite;
    logic [2:0]      out_class;

    modport slave (
        input  in_valid, in_instr, in_pc,
        input  rf_rd_data1, rf_rd_data2,
        input  wb_valid, wb_reg, wb_data,
        input  flush, out_ready,
        output in_ready, rf_rd_addr1, rf_rd_addr2,
        output out_valid, out_pc, out_op1, out_op2, out_imm,
        output out_rd, out_regwrite, out_class
    );

    modport master (
        output in_valid, in_instr, in_pc,
        output rf_rd_data1, rf_rd_data2,
        output wb_valid, wb_reg, wb_data,
        output flush, out_ready,
        input  in_ready, rf_rd_addr1, rf_rd_addr2,
        input  out_valid, out_pc, out_op1, out_op2, out_imm,
        input  out_rd, out_regwrite, out_class
    );
endinterface

// File: rtl/id_issue_stage.sv
// LEGv8 decode/issue stage. Decodes the fetched word, drives the register file
// read ports, bypasses same-cycle writeback data around the register file,
// tracks in-flight destinations in a busy scoreboard to stall on RAW/WAW
// hazards, and holds the ID/EX pipeline register under valid/ready.
// Register 31 is XZR: it reads as zero and is never busy. Instructions that
// write no register report out_rd = 31.
module id_issue_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic           clk,
    input  logic           rst,
    id_issue_stage_if.slave bus
);

    localparam logic [4:0] ZR = 5'(NREG - 1);

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_RALU = 3'd1,
        CLS_IALU = 3'd2,
        CLS_LDUR = 3'd3,
        CLS_STUR = 3'd4,
        CLS_CBZ  = 3'd5,
        CLS_B    = 3'd6
    } class_e;

    // Scoreboard and ID/EX register state
    logic [NREG-1:0] busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_op1_q, out_op1_d;
    logic [XLEN-1:0] out_op2_q, out_op2_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            out_regwrite_q, out_regwrite_d;
    logic [2:0]      out_class_q, out_class_d;

    // Decode results for the word currently offered by fetch
    logic [4:0]      addr1, addr2, rdField;
    logic            writes;
    logic [XLEN-1:0] imm;
    class_e          cls;

    logic [NREG-1:0] busyLive;
    logic [XLEN-1:0] op1, op2;
    logic            hazard, advance, inReady, issue;

    // Field extraction per instruction format; unused read ports point at XZR
    always_comb begin
        addr1   = ZR;
        addr2   = ZR;
        rdField = ZR;
        writes  = 1'b0;
        imm     = '0;
        cls     = CLS_NOP;
        if (bus.in_instr[31:21] inside {11'b10001011000, 11'b11001011000,
                                        11'b10001010000, 11'b10101010000}) begin
            addr1   = bus.in_instr[9:5];
            addr2   = bus.in_instr[20:16];
            rdField = bus.in_instr[4:0];
            writes  = 1'b1;
            cls     = CLS_RALU;
        end else if (bus.in_instr[31:22] inside {10'b1001000100, 10'b1101000100}) begin
            addr1   = bus.in_instr[9:5];
            rdField = bus.in_instr[4:0];
            writes  = 1'b1;
            imm     = {{(XLEN-12){1'b0}}, bus.in_instr[21:10]};
            cls     = CLS_IALU;
        end else if (bus.in_instr[31:21] == 11'b11111000010) begin
            addr1   = bus.in_instr[9:5];
            rdField = bus.in_instr[4:0];
            writes  = 1'b1;
            imm     = {{(XLEN-9){bus.in_instr[20]}}, bus.in_instr[20:12]};
            cls     = CLS_LDUR;
        end else if (bus.in_instr[31:21] == 11'b11111000000) begin
            addr1   = bus.in_instr[9:5];
            addr2   = bus.in_instr[4:0];
            imm     = {{(XLEN-9){bus.in_instr[20]}}, bus.in_instr[20:12]};
            cls     = CLS_STUR;
        end else if (bus.in_instr[31:24] == 8'b10110100) begin
            addr2   = bus.in_instr[4:0];
            imm     = {{(XLEN-19){bus.in_instr[23]}}, bus.in_instr[23:5]};
            cls     = CLS_CBZ;
        end else if (bus.in_instr[31:26] == 6'b000101) begin
            imm     = {{(XLEN-26){bus.in_instr[25]}}, bus.in_instr[25:0]};
            cls     = CLS_B;
        end
        if (rdField == ZR) begin
            writes = 1'b0;
        end
    end

    // Operand selection: XZR is zero, a same-cycle writeback overrides the regfile
    always_comb begin
        op1 = bus.rf_rd_data1;
        op2 = bus.rf_rd_data2;
        if (addr1 == ZR) begin
            op1 = '0;
        end else if (bus.wb_valid && bus.wb_reg == addr1) begin
            op1 = bus.wb_data;
        end
        if (addr2 == ZR) begin
            op2 = '0;
        end else if (bus.wb_valid && bus.wb_reg == addr2) begin
            op2 = bus.wb_data;
        end
    end

    // Hazard detection against busy bits, ignoring any register retiring right now
    always_comb begin
        busyLive = busy_q;
        if (bus.wb_valid) begin
            busyLive[bus.wb_reg] = 1'b0;
        end
        busyLive[NREG-1] = 1'b0;
        hazard  = busyLive[addr1] | busyLive[addr2] | (writes & busyLive[rdField]);
        advance = !out_valid_q || bus.out_ready;
        inReady = rst && advance && !hazard && !bus.flush;
        issue   = bus.in_valid && inReady;
    end

    // Scoreboard next state: retire and flush clear first so a new issue wins
    always_comb begin
        busy_d = busy_q;
        if (bus.wb_valid) begin
            busy_d[bus.wb_reg] = 1'b0;
        end
        if (bus.flush && out_valid_q && out_regwrite_q) begin
            busy_d[out_rd_q] = 1'b0;
        end
        if (issue && writes) begin
            busy_d[rdField] = 1'b1;
        end
        busy_d[NREG-1] = 1'b0;
    end

    // ID/EX next state: kill on flush, load on issue, drain when EX takes it
    always_comb begin
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_op1_d      = out_op1_q;
        out_op2_d      = out_op2_q;
        out_imm_d      = out_imm_q;
        out_rd_d       = out_rd_q;
        out_regwrite_d = out_regwrite_q;
        out_class_d    = out_class_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d    = 1'b1;
            out_pc_d       = bus.in_pc;
            out_op1_d      = op1;
            out_op2_d      = op2;
            out_imm_d      = imm;
            out_rd_d       = rdField;
            out_regwrite_d = writes;
            out_class_d    = cls;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q         <= '0;
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_op1_q      <= '0;
            out_op2_q      <= '0;
            out_imm_q      <= '0;
            out_rd_q       <= '0;
            out_regwrite_q <= 1'b0;
            out_class_q    <= '0;
        end else begin
            busy_q         <= busy_d;
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_op1_q      <= out_op1_d;
            out_op2_q      <= out_op2_d;
            out_imm_q      <= out_imm_d;
            out_rd_q       <= out_rd_d;
            out_regwrite_q <= out_regwrite_d;
            out_class_q    <= out_class_d;
        end
    end

    assign bus.in_ready     = inReady;
    assign bus.rf_rd_addr1  = addr1;
    assign bus.rf_rd_addr2  = addr2;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_op1      = out_op1_q;
    assign bus.out_op2      = out_op2_q;
    assign bus.out_imm      = out_imm_q;
    assign bus.out_rd       = out_rd_q;
    assign bus.out_regwrite = out_regwrite_q;
    assign bus.out_class    = out_class_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed instruction vectors with hand-computed
// ID/EX contents pushed into a queue, and a monitor that pops and compares
// every entry EX accepts. Stall, hold, flush and reset behaviour are checked
// inline by the stimulus process.
module tb_id_issue_stage;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic [2:0]  cls;
    } entry_t;

    logic clk;
    logic rst;
    logic [63:0] rfMem [32];
    entry_t expQ[$];
    int vectors = 0;
    int errors  = 0;

    id_issue_stage_if #(.XLEN(64)) bus ();

    id_issue_stage #(.XLEN(64), .NREG(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Combinational register file model with no internal bypass
    assign bus.rf_rd_data1 = rfMem[bus.rf_rd_addr1];
    assign bus.rf_rd_data2 = rfMem[bus.rf_rd_addr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic entry_t mk(input logic [63:0] pc, input logic [63:0] op1,
                                  input logic [63:0] op2, input logic [63:0] imm,
                                  input logic [4:0] rd, input logic rw,
                                  input logic [2:0] cls);
        entry_t e;
        e.pc = pc; e.op1 = op1; e.op2 = op2; e.imm = imm;
        e.rd = rd; e.rw = rw; e.cls = cls;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [63:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    task automatic waitIssue(input string name, input int expStalls);
        int  stalls = 0;
        bit  got    = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                got = 1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        if (got) begin
            @(posedge clk); #1;
            checkOutput({name, "_stalls"}, 64'(stalls), 64'(expStalls));
        end else begin
            vectors++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no issue, expected issue within 20 cycles", name);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic issueOne(input logic [31:0] instr, input logic [63:0] pc,
                            input entry_t e, input string name);
        applyStimulus(instr, pc);
        waitIssue(name, 0);
        expQ.push_back(e);
    endtask

    task automatic retire(input logic [4:0] r, input logic [63:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_reg   = r;
        bus.wb_data  = d;
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
    endtask

    // Monitor: every entry EX accepts must match the oldest expected entry
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1 &&
            bus.flush === 1'b0) begin
            if (expQ.size() == 0) begin
                vectors++;
                errors++;
                $display("[TB] FAIL unexpected_entry: got pc 0x%0h, expected no entry", bus.out_pc);
            end else begin
                entry_t e;
                e = expQ.pop_front();
                checkOutput("out_pc", bus.out_pc, e.pc);
                checkOutput("out_op1", bus.out_op1, e.op1);
                checkOutput("out_op2", bus.out_op2, e.op2);
                checkOutput("out_imm", bus.out_imm, e.imm);
                checkOutput("out_rd", 64'(bus.out_rd), 64'(e.rd));
                checkOutput("out_regwrite", 64'(bus.out_regwrite), 64'(e.rw));
                checkOutput("out_class", 64'(bus.out_class), 64'(e.cls));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.wb_valid  = 1'b0;
        bus.wb_reg    = '0;
        bus.wb_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) rfMem[i] = 64'h1000 + 64'(i);
        rfMem[2]  = 64'd5;
        rfMem[3]  = 64'd9;
        rfMem[4]  = 64'h111;
        rfMem[31] = 64'hDEAD;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_regwrite", 64'(bus.out_regwrite), 64'd0);
        checkOutput("rst_out_class", 64'(bus.out_class), 64'd0);
        checkOutput("rst_out_rd", 64'(bus.out_rd), 64'd0);
        checkOutput("rst_out_pc", bus.out_pc, 64'd0);
        checkOutput("rst_out_op1", bus.out_op1, 64'd0);
        checkOutput("rst_out_op2", bus.out_op2, 64'd0);
        checkOutput("rst_out_imm", bus.out_imm, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // ADD X1,X2,X3 then ADDI X5,XZR,#7
        issueOne(32'h8B030041, 64'h100, mk(64'h100, 64'd5, 64'd9, 64'd0, 5'd1, 1'b1, 3'd1), "add_x1");
        issueOne(32'h91001FE5, 64'h104, mk(64'h104, 64'd0, 64'd0, 64'd7, 5'd5, 1'b1, 3'd2), "addi_x5");
        retire(5'd1, 64'hAAAA);
        retire(5'd5, 64'hBBBB);

        // LDUR X4,[X5] then dependent ADD X6,X4,X4 released by writeback bypass
        issueOne(32'hF84000A4, 64'h108, mk(64'h108, 64'h1005, 64'd0, 64'd0, 5'd4, 1'b1, 3'd3), "ldur_x4");
        applyStimulus(32'h8B040086, 64'h10C);
        repeat (3) begin
            @(negedge clk);
            checkOutput("raw_stall", 64'(bus.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5'd4;
        bus.wb_data  = 64'h444;
        waitIssue("add_x6", 0);
        bus.wb_valid = 1'b0;
        expQ.push_back(mk(64'h10C, 64'h444, 64'h444, 64'd0, 5'd6, 1'b1, 3'd1));

        // Back-pressure: ORR held three cycles, SUB issues on first ready cycle
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        issueOne(32'hAA030048, 64'h110, mk(64'h110, 64'd5, 64'd9, 64'd0, 5'd8, 1'b1, 3'd1), "orr_x8");
        applyStimulus(32'hCB02006A, 64'h114);
        repeat (3) begin
            @(negedge clk);
            checkOutput("hold_out_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("hold_out_pc", bus.out_pc, 64'h110);
            checkOutput("hold_out_op1", bus.out_op1, 64'd5);
            checkOutput("hold_out_op2", bus.out_op2, 64'd9);
            checkOutput("hold_out_rd", 64'(bus.out_rd), 64'd8);
            checkOutput("hold_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        waitIssue("sub_x10", 0);
        expQ.push_back(mk(64'h114, 64'd9, 64'd5, 64'd0, 5'd10, 1'b1, 3'd1));
        @(posedge clk); #1;

        // Flush kills a held ADD X1 and frees X1 for the next reader
        bus.out_ready = 1'b0;
        applyStimulus(32'h8B030041, 64'h118);
        waitIssue("add_x1_flushed", 0);
        bus.flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("flush_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        issueOne(32'h91000C2B, 64'h11C, mk(64'h11C, 64'h1001, 64'd0, 64'd3, 5'd11, 1'b1, 3'd2), "addi_read_x1");

        // WAW on X7 released by same-cycle retire; the new set must win
        issueOne(32'h91000447, 64'h120, mk(64'h120, 64'd5, 64'd0, 64'd1, 5'd7, 1'b1, 3'd2), "addi_x7a");
        applyStimulus(32'h91000867, 64'h124);
        @(negedge clk);
        checkOutput("waw_stall", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5'd7;
        bus.wb_data  = 64'h777;
        waitIssue("addi_x7b", 0);
        bus.wb_valid = 1'b0;
        expQ.push_back(mk(64'h124, 64'd9, 64'd0, 64'd2, 5'd7, 1'b1, 3'd2));
        applyStimulus(32'h8B0200EC, 64'h128);
        repeat (2) begin
            @(negedge clk);
            checkOutput("set_wins_stall", 64'(bus.in_ready), 64'd0);
            @(posedge clk); #1;
        end

        // Reset while stalled discards the reader and clears the scoreboard
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        issueOne(32'h8B0200EC, 64'h12C, mk(64'h12C, 64'h1007, 64'd5, 64'd0, 5'd12, 1'b1, 3'd1), "add_x12_post_rst");

        // Remaining formats and immediate boundaries
        issueOne(32'hF81F8062, 64'h130, mk(64'h130, 64'd9, 64'd5, 64'hFFFF_FFFF_FFFF_FFF8, 5'd31, 1'b0, 3'd4), "stur");
        issueOne(32'hB4FFFFC3, 64'h134, mk(64'h134, 64'd0, 64'd9, 64'hFFFF_FFFF_FFFF_FFFE, 5'd31, 1'b0, 3'd5), "cbz");
        issueOne(32'h14000010, 64'h138, mk(64'h138, 64'd0, 64'd0, 64'h10, 5'd31, 1'b0, 3'd6), "b");
        issueOne(32'hFFFFFFFF, 64'h13C, mk(64'h13C, 64'd0, 64'd0, 64'd0, 5'd31, 1'b0, 3'd0), "illegal");
        issueOne(32'h8B03005F, 64'h140, mk(64'h140, 64'd5, 64'd9, 64'd0, 5'd31, 1'b0, 3'd1), "add_xzr");
        issueOne(32'hF85FF04D, 64'h144, mk(64'h144, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 1'b1, 3'd3), "ldur_neg");
        issueOne(32'h913FFC4E, 64'h148, mk(64'h148, 64'd5, 64'd0, 64'hFFF, 5'd14, 1'b1, 3'd2), "addi_max");

        repeat (4) @(posedge clk);
        #1;
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode/issue stage of the 5-stage LEGv8 pipeline. Sits directly upstream of the 64x32 register file and directly downstream of fetch.
- Decodes register fields and drives regfile read addresses. Applies the write-to-read bypass the regfile lacks.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards.
- Holds the ID/EX pipeline register under a valid/ready handshake.

Parameters:
XLEN, 64, datapath width
NREG, 32, architectural registers; index NREG-1 is XZR (reads zero, never busy)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
in_valid  in  1  fetch holds an instruction
in_ready  out  1  stage accepts in_instr this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of in_instr
rf_rd_addr1  out  5  regfile ReadRegister1
rf_rd_addr2  out  5  regfile ReadRegister2
rf_rd_data1  in  XLEN  regfile ReadData1 (combinational)
rf_rd_data2  in  XLEN  regfile ReadData2
wb_valid  in  1  writeback retiring a register write this cycle
wb_reg  in  5  writeback destination
wb_data  in  XLEN  writeback data (also regfile WriteData)
flush  in  1  kill ID/EX entry (branch taken in EX)
out_valid  out  1  ID/EX entry valid
out_ready  in  1  EX accepts entry
out_pc  out  XLEN  PC
out_op1  out  XLEN  Rn operand
out_op2  out  XLEN  Rm / Rt operand
out_imm  out  XLEN  sign/zero-extended immediate
out_rd  out  5  destination register
out_regwrite  out  1  entry writes out_rd
out_class  out  3  0 NOP/illegal, 1 R-ALU, 2 I-ALU, 3 LDUR, 4 STUR, 5 CBZ, 6 B

Behaviour:
Decode:
- R (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): addr1=[9:5], addr2=[20:16], rd=[4:0], regwrite=1.
- I (ADDI 1001000100, SUBI 1101000100): imm=zext [21:10], addr1=[9:5], rd=[4:0], regwrite=1.
- LDUR 11111000010: imm=sext [20:12], addr1=[9:5], rd=[4:0], regwrite=1.
- STUR 11111000000: imm=sext [20:12], addr1=[9:5], addr2=[4:0], regwrite=0.
- CBZ 10110100: imm=sext [23:5], addr2=[4:0], regwrite=0.
- B 000101: imm=sext [25:0], regwrite=0.
- Anything else: class 0, regwrite=0, no sources.
- Unused read address is driven to 31.
- rd==31 forces regwrite=0.

Operands:
- Each source is wb_data if wb_valid && wb_reg==addr && addr!=31.
- Otherwise it is rf_rd_data. Source 31 always yields 0.

Scoreboard (busy[NREG-1:0]):
- hazard = any used source busy, or (regwrite && busy[rd]).
- A busy bit whose register is being retired by wb this cycle counts as not busy.
- busy[31] is constant 0.

Handshake:
- advance = !out_valid || out_ready.
- in_ready = advance && !hazard && !flush.
- Issue on in_valid && in_ready: the ID/EX register loads in the same edge, so there is one cycle of latency.
- On issue with regwrite: busy[rd] <= 1.
- On wb_valid: busy[wb_reg] <= 0.
- Same reg set and cleared in the same cycle: set wins.
- out_valid <= 0 when out_ready && !issue.
- ID/EX holds all fields stable while out_valid && !out_ready.

Flush:
- out_valid <= 0. If the killed entry had regwrite, its busy bit is cleared (unless wb is setting it again).
- No issue occurs in a flush cycle.

Reset (rst==0 at posedge):
- busy=0, out_valid=0, out_regwrite=0, out_class=0, out_rd=0, and out_pc, out_op1, out_op2, out_imm all 0.
- Reset mid-stall discards the pending instruction.
- in_ready is 0 while rst==0.

Test Plan:
- Reset, regfile X2=5, X3=9, in_instr=0x8B030041 (ADD X1,X2,X3), out_ready=1 -> next cycle out_valid=1, out_op1=5, out_op2=9, out_rd=1, out_class=1, busy[1]=1.
- in_instr=0x91001FE5 (ADDI X5,XZR,#7) -> out_op1=0, out_imm=7, out_rd=5, no stall from Rn=31.
- LDUR X4,[X5] (0xF84000A4) then ADD X6,X4,X4 (0x8B040086):
  - ADD is held with in_ready=0 until wb_valid with wb_reg=4.
  - In that wb cycle ADD issues with out_op1=out_op2=wb_data.
- out_ready=0 for 3 cycles with out_valid=1 -> ID/EX fields unchanged, in_ready=0. Release -> next instruction issues on the first ready cycle.
- Issue ADD X1 then assert flush -> out_valid=0, busy[1]=0. A following read of X1 proceeds without stall.
- Busy[7] set; in the same cycle, a new writer to X7 issues and wb retires X7 -> busy[7]=1 after the edge. Drive rst=0 mid-stall -> all busy=0, out_valid=0.
